lsu_align_ctrl: RTL
===================

// Module: lsu_align_ctrl
// PURPOSE
//  Load/store alignment controller sitting directly upstream of the data memory.
//  Takes MEM-stage requests (addr, funct3, store data) and drives word-aligned
//  accesses with byte strobes. Splits boundary-crossing accesses into two cycles
//  and returns sign/zero-extended load data, registered, to the MEM/WB stage.
//  Big-endian lanes: byte at word offset k <-> data[31-8k:24-8k], strobe bit 3-k.
// PARAMETERS
//  ADDR_W  12  byte address width (matches data-memory address width)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       synchronous active-low reset
//  in_valid     in   1       request present
//  in_ready     out  1       request accepted when in_valid&&in_ready at posedge
//  in_load      in   1       load request
//  in_store     in   1       store request
//  in_funct3    in   3       RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  in_addr      in   ADDR_W  byte address
//  in_wdata     in   32      store data, LSB-aligned
//  Mem_r        out  1       memory read enable
//  Mem_w        out  1       memory write enable
//  Mem_Addr     out  ADDR_W  word-aligned address, [1:0] always 2'b00
//  Mem_W_Data   out  32      lane-positioned write data
//  Mem_W_Strb   out  4       byte-lane write strobes
//  Mem_R_Data   in   32      combinational read data, same cycle as Mem_r
//  out_valid    out  1       one-cycle pulse: access complete
//  out_rdata    out  32      extended load data (0 for stores/errors)
//  out_err      out  1       illegal request; qualifies out_valid
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out_rdata=0, out_err=0. Partial-data register = 0.
//  Mem_* outputs are combinational from state and request.
//  Mem_r=Mem_w=0 whenever no access is issued.
//  Size n: funct3[1:0]=00 ->1, 01 ->2, 10 ->4. Offset o=in_addr[1:0]. A=in_addr&~3.
//  Legal: exactly one of in_load/in_store.
//   Load funct3 in {000,001,010,100,101}; store funct3 in {000,001,010}.
//  FSM IDLE:
//   - in_ready=1.
//   - Illegal request: no memory access; next cycle out_valid=1, out_err=1, out_rdata=0.
//   - Legal, o+n<=4: single access at A, lanes o..o+n-1. Stay IDLE.
//     Next cycle out_valid=1, out_rdata = extended load.
//     Back-to-back requests every cycle are supported.
//   - Legal, o+n>4 (split): first access at A, lanes o..3.
//     Load bytes are captured into the partial register. Go SECOND.
//  FSM SECOND:
//   - in_ready=0.
//   - Access at (A+4) mod 2^ADDR_W, lanes 0..o+n-5, using the latched request.
//   - Go IDLE. Next cycle out_valid=1 with combined data.
//  Split accesses: 2 cycles, no bubble, one out_valid.
//  Load result:
//   - Bytes are ordered lowest address = most significant.
//   - LB/LH sign-extend from the top result bit; LBU/LHU zero-extend.
//  Store data: in_wdata[8n-1:0] is placed MSB-first starting at lane o.
//   Split stores carry the remaining bytes into lanes 0.. of A+4.
//   Unstrobed lanes of Mem_W_Data are 0.
//  out_valid/out_err are cleared the cycle after they are asserted unless a new
//   completion occurs.
//  Reset mid-split: the second access is never issued; the FSM returns to IDLE.
//   No out_valid is produced.
//  Request fields are latched on acceptance. Inputs are ignored while in SECOND.
// TESTING
//  1) Mem 0x10..0x13=11 22 33 44; LW @0x10 -> one access Mem_Addr=0x10 Mem_r=1;
//     next cycle out_valid=1, out_rdata=0x11223344; in_ready stays 1.
//  2) Mem 0x13=0x80, 0x14=0x01; LH @0x13 -> Mem_Addr 0x10 then 0x14; in_ready=0
//     in cycle 2; out_rdata=0xFFFF8001. LHU @0x13 -> 0x00008001.
//  3) SW @0x0E data 0xAABBCCDD -> cycle1 Mem_Addr=0x0C Strb=0011 Data=0x0000AABB;
//     cycle2 Mem_Addr=0x10 Strb=1100 Data=0xCCDD0000.
//  4) SB @0x05 data 0x000000EE -> Mem_Addr=0x04 Strb=0100 Data=0x00EE0000;
//     LB @0x05 on byte 0xEE -> 0xFFFFFFEE.
//  5) SW @0xFFE (ADDR_W=12) -> second access Mem_Addr=0x000 Strb=1100.
//     Assert rst_n=0 during SECOND -> no second access, out_valid stays 0.
//  6) in_load=in_store=1, or load funct3=011 -> Mem_r=Mem_w=0;
//     next cycle out_valid=1, out_err=1, out_rdata=0.

Source files
------------

// File: rtl/lsu_align_ctrl_if.sv
// Request, data-memory and response signals of the load/store alignment controller.
// The controller takes the slave view; the pipeline/memory environment takes the master view.
interface lsu_align_ctrl_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic              in_load;
    logic              in_store;
    logic [2:0]        in_funct3;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_wdata;

    logic              Mem_r;
    logic              Mem_w;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_W_Data;
    logic [3:0]        Mem_W_Strb;
    logic [31:0]       Mem_R_Data;

    logic              out_valid;
    logic [31:0]       out_rdata;
    logic              out_err;

    modport master (
        output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, Mem_R_Data,
        input  in_ready, Mem_r, Mem_w, Mem_Addr, Mem_W_Data, Mem_W_Strb,
        input  out_valid, out_rdata, out_err
    );

    modport slave (
        input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, Mem_R_Data,
        output in_ready, Mem_r, Mem_w, Mem_Addr, Mem_W_Data, Mem_W_Strb,
        output out_valid, out_rdata, out_err
    );
endinterface

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: word-aligned big-endian memory accesses with byte strobes,
// two-cycle split for boundary-crossing accesses, registered extended load data.
module lsu_align_ctrl #(
    parameter int unsigned ADDR_W = 12
) (
    input logic             clk,
    input logic             rst_n,
    lsu_align_ctrl_if.slave bus
);

    typedef enum logic {StIdle, StSecond} state_e;

    state_e            state_q, state_d;
    logic              load_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       partial_q;
    logic              out_valid_q;
    logic              out_err_q;
    logic [31:0]       out_rdata_q;

    logic              in_second;
    logic              cur_load;
    logic [2:0]        cur_f3;
    logic [1:0]        cur_off;
    logic [31:0]       cur_wdata;
    logic [31:0]       hi_word;
    logic [2:0]        size_n;
    logic [5:0]        pad_sh;
    logic [5:0]        off_sh;
    logic [7:0]        lane_mask;
    logic [63:0]       wr64;
    logic [31:0]       rd_top;
    logic [31:0]       rd_raw;
    logic [31:0]       load_data;
    logic              legal;
    logic              split;
    logic              done;
    logic              done_err;
    logic [31:0]       done_rdata;
    logic              capture;

    // Datapath works on the live request in IDLE and on the latched one in SECOND.
    always_comb begin
        in_second = (state_q == StSecond);
        cur_load  = in_second ? load_q   : bus.in_load;
        cur_f3    = in_second ? funct3_q : bus.in_funct3;
        cur_off   = in_second ? off_q    : bus.in_addr[1:0];
        cur_wdata = in_second ? wdata_q  : bus.in_wdata;
        hi_word   = in_second ? partial_q : bus.Mem_R_Data;

        size_n    = 3'd1 << cur_f3[1:0];
        pad_sh    = {3'd4 - size_n, 3'b000};
        off_sh    = {1'b0, cur_off, 3'b000};
        // Eight lanes spanning word A (bits 7:4) and word A+4 (bits 3:0).
        lane_mask = (8'hFF << (4'd8 - {1'b0, size_n})) >> cur_off;
        split     = |lane_mask[3:0];

        wr64      = {cur_wdata << pad_sh, 32'h0} >> off_sh;

        rd_top    = (hi_word << off_sh) | (bus.Mem_R_Data >> (6'd32 - off_sh));
        rd_raw    = rd_top >> pad_sh;
        case (cur_f3[1:0])
            2'b00:   load_data = {{24{~cur_f3[2] & rd_raw[7]}}, rd_raw[7:0]};
            2'b01:   load_data = {{16{~cur_f3[2] & rd_raw[15]}}, rd_raw[15:0]};
            default: load_data = rd_raw;
        endcase

        legal = 1'b0;
        if (bus.in_load && !bus.in_store) begin
            legal = bus.in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else if (bus.in_store && !bus.in_load) begin
            legal = bus.in_funct3 inside {3'b000, 3'b001, 3'b010};
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.in_ready   = 1'b0;
        bus.Mem_r      = 1'b0;
        bus.Mem_w      = 1'b0;
        bus.Mem_Addr   = '0;
        bus.Mem_W_Data = '0;
        bus.Mem_W_Strb = '0;
        done           = 1'b0;
        done_err       = 1'b0;
        done_rdata     = '0;
        capture        = 1'b0;

        case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (!legal) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                    end else begin
                        bus.Mem_r      = bus.in_load;
                        bus.Mem_w      = bus.in_store;
                        bus.Mem_Addr   = {bus.in_addr[ADDR_W-1:2], 2'b00};
                        bus.Mem_W_Strb = bus.in_store ? lane_mask[7:4] : 4'b0000;
                        bus.Mem_W_Data = bus.in_store ? wr64[63:32] : 32'h0;
                        if (split) begin
                            capture = 1'b1;
                            state_d = StSecond;
                        end else begin
                            done       = 1'b1;
                            done_rdata = bus.in_load ? load_data : 32'h0;
                        end
                    end
                end
            end
            StSecond: begin
                bus.Mem_r      = load_q;
                bus.Mem_w      = ~load_q;
                bus.Mem_Addr   = addr_q + ADDR_W'(4);
                bus.Mem_W_Strb = load_q ? 4'b0000 : lane_mask[3:0];
                bus.Mem_W_Data = load_q ? 32'h0 : wr64[31:0];
                done           = 1'b1;
                done_rdata     = load_q ? load_data : 32'h0;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A reset cycle never issues an access, including an abandoned second half.
        if (!rst_n) begin
            bus.in_ready = 1'b0;
            bus.Mem_r    = 1'b0;
            bus.Mem_w    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            load_q      <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            partial_q   <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= done;
            out_err_q   <= done_err;
            if (done) begin
                out_rdata_q <= done_rdata;
            end
            if (capture) begin
                load_q    <= bus.in_load;
                funct3_q  <= bus.in_funct3;
                off_q     <= bus.in_addr[1:0];
                addr_q    <= {bus.in_addr[ADDR_W-1:2], 2'b00};
                wdata_q   <= bus.in_wdata;
                partial_q <= bus.in_load ? bus.Mem_R_Data : 32'h0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_rdata = out_rdata_q;

endmodule
